// File: rtl/libfifo_pkg.sv
// Shared types and helpers for the fifo library: burst-drain FSM states,
// fill-level width calculation and the fifo fill status record.
package libfifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } burstState_t;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic almost_full;
        logic full;
    } fillStatus;

    // Width of a fill-level count able to hold 0..depth inclusive.
    function automatic int fillBits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_skid_buffer.sv
// Small register fifo that absorbs words already popped from the main fifo
// while the downstream stream is stalled. clr_n is a synchronous active-low clear.
module fifo_skid_buffer #(
    parameter int WIDTH      = 32,
    parameter int SKID_DEPTH = 2,
    localparam int CW        = $clog2(SKID_DEPTH + 1),
    localparam int PW        = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(SKID_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign do_pop_s  = pop_i && (count_q != '0);
    assign do_push_s = push_i && ((count_q != CW'(SKID_DEPTH)) || do_pop_s);
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CW'(1);
        end else if (!do_push_s && do_pop_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Storage, pointers and count registers.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_burst_drain.sv
// Burst drain stage: pops whole bursts from the fifo and replays them as a
// valid/ready stream with a last flag. Optional idle-timeout partial bursts
// are built when FIFO_BURST_TIMEOUT_EN is defined.
module fifo_burst_drain
    import libfifo_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int BURST_LEN    = 8,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 64,
    localparam int FILLBITS    = fillBits(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    fifo_dataout,
    input  logic [FILLBITS-1:0] fifo_fill_level,
    output logic                fifo_read,
    input  logic                flush,
    output logic [WIDTH-1:0]    m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic                busy
);

    localparam int SKID_DEPTH = READ_LATENCY + 1;
    localparam int IFW        = $clog2(READ_LATENCY + 1);
    localparam int SCW        = $clog2(SKID_DEPTH + 1);
    localparam int OW         = SCW + 1;
    localparam logic [FILLBITS-1:0] BURST_LEN_F = FILLBITS'(BURST_LEN);

    burstState_t             state_q, state_d;
    logic [FILLBITS-1:0]     burst_len_q, burst_len_d;
    logic [FILLBITS-1:0]     reads_issued_q, reads_issued_d;
    logic [FILLBITS-1:0]     delivered_q, delivered_d;
    logic [IFW-1:0]          in_flight_q, in_flight_d;
    logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic                    flush_q, flush_d;
    logic                    capture_s;
    logic                    xfer_s;
    logic                    last_xfer_s;
    logic                    start_s;
    logic                    clear_s;
    logic                    timeout_hit_s;
    logic                    skid_empty_s;
    logic [SCW-1:0]          skid_count_s;
    logic [OW-1:0]           occ_s;

    fifo_skid_buffer #(
        .WIDTH      (WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk         (clk),
        .clr_n       (reset),
        .push_i      (capture_s),
        .push_data_i (fifo_dataout),
        .pop_i       (xfer_s),
        .head_o      (m_data),
        .count_o     (skid_count_s),
        .empty_o     (skid_empty_s)
    );

    assign capture_s   = rd_pipe_q[READ_LATENCY-1];
    assign m_valid     = !skid_empty_s;
    assign xfer_s      = m_valid && m_ready;
    assign m_last      = m_valid && (delivered_q == (burst_len_q - FILLBITS'(1)));
    assign last_xfer_s = xfer_s && m_last;
    assign busy        = (state_q != IDLE);
    // A slot freed by this cycle's transfer may be refilled by this cycle's read.
    assign occ_s       = OW'(in_flight_q) + OW'(skid_count_s) - OW'(xfer_s);

    // Read-strobe delay line and count of reads whose data has not yet landed.
    always_comb begin
        rd_pipe_d   = READ_LATENCY'({rd_pipe_q, fifo_read});
        in_flight_d = in_flight_q;
        case ({fifo_read, capture_s})
            2'b10:   in_flight_d = in_flight_q + IFW'(1);
            2'b01:   in_flight_d = in_flight_q - IFW'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    // Burst FSM next state, read strobe and burst counters.
    always_comb begin
        state_d        = state_q;
        burst_len_d    = burst_len_q;
        reads_issued_d = reads_issued_q;
        delivered_d    = delivered_q;
        fifo_read      = 1'b0;
        start_s        = 1'b0;
        clear_s        = 1'b0;
        if (xfer_s) begin
            delivered_d = delivered_q + FILLBITS'(1);
        end else begin
            delivered_d = delivered_q;
        end
        case (state_q)
            IDLE: begin
                if (fifo_fill_level >= BURST_LEN_F) begin
                    start_s     = 1'b1;
                    burst_len_d = BURST_LEN_F;
                end else if (flush_q && (fifo_fill_level != '0)) begin
                    start_s     = 1'b1;
                    burst_len_d = fifo_fill_level;
                end else if (flush_q) begin
                    clear_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                fifo_read = (reads_issued_q < burst_len_q) && (occ_s < OW'(SKID_DEPTH));
                if (fifo_read) begin
                    reads_issued_d = reads_issued_q + FILLBITS'(1);
                end else begin
                    reads_issued_d = reads_issued_q;
                end
                if (last_xfer_s) begin
                    state_d = IDLE;
                end else if (reads_issued_d == burst_len_q) begin
                    state_d = DRAIN;
                end else begin
                    state_d = BURST;
                end
            end
            DRAIN: begin
                if (last_xfer_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (start_s) begin
            state_d        = BURST;
            reads_issued_d = '0;
            delivered_d    = '0;
        end else begin
            state_d = state_d;
        end
    end

`ifdef FIFO_BURST_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0] idle_cnt_q, idle_cnt_d;

    // Count idle cycles spent holding a partial burst; saturates at TIMEOUT.
    always_comb begin
        idle_cnt_d = '0;
        if ((state_q == IDLE) && !start_s && (fifo_fill_level != '0)
            && (fifo_fill_level < BURST_LEN_F)) begin
            if (idle_cnt_q != TCW'(TIMEOUT)) begin
                idle_cnt_d = idle_cnt_q + TCW'(1);
            end else begin
                idle_cnt_d = idle_cnt_q;
            end
        end else begin
            idle_cnt_d = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign timeout_hit_s = (idle_cnt_d == TCW'(TIMEOUT));
`else
    // No idle counter in this build; the compare is never true for a valid TIMEOUT.
    assign timeout_hit_s = (TIMEOUT < 0);
`endif

    // Flush latch: a new request always wins over the clear at burst start.
    always_comb begin
        flush_d = flush_q;
        if (flush) begin
            flush_d = 1'b1;
        end else if (start_s || clear_s) begin
            flush_d = 1'b0;
        end else if (timeout_hit_s) begin
            flush_d = 1'b1;
        end else begin
            flush_d = flush_q;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            burst_len_q    <= '0;
            reads_issued_q <= '0;
            delivered_q    <= '0;
            in_flight_q    <= '0;
            rd_pipe_q      <= '0;
            flush_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            burst_len_q    <= burst_len_d;
            reads_issued_q <= reads_issued_d;
            delivered_q    <= delivered_d;
            in_flight_q    <= in_flight_d;
            rd_pipe_q      <= rd_pipe_d;
            flush_q        <= flush_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Directed bench for fifo_burst_drain with a behavioural fifo (read latency 1).
module tb_fifo_burst_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        m_ready;
    logic [31:0] fifo_dataout = 32'd0;
    logic [5:0]  fifo_fill_level;
    logic        fifo_read;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        busy;

    logic [31:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          total  = 0;
    int          bad    = 0;

    fifo_burst_drain dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_dataout    (fifo_dataout),
        .fifo_fill_level (fifo_fill_level),
        .fifo_read       (fifo_read),
        .flush           (flush),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    assign fifo_fill_level = 6'(wr_ptr - rd_ptr);

    // Fifo model: registered read port, emptied by reset.
    always @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_read) begin
            fifo_dataout <= mem[rd_ptr % 256];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 256] = base + 32'(i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; flush = 1'b0; m_ready = 1'b1;
        tick; tick;
        total += 5;
        if (fifo_read !== 1'b0) begin bad++; $display("FAIL reset_read got=%b want=0", fifo_read); end
        if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", m_valid); end
        if (m_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", m_last); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (m_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", m_data); end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_full_burst;
        logic [3:0]  exp_ctl;
        logic [31:0] exp_data;
        m_ready = 1'b1;
        push_words(32'h10, 8);
        for (int k = 0; k < 14; k++) begin
            exp_ctl  = {(k >= 1 && k <= 8), (k >= 3 && k <= 10), (k == 10), (k >= 1 && k <= 10)};
            exp_data = 32'h10 + 32'(k - 3);
            total++;
            if ({fifo_read, m_valid, m_last, busy} !== exp_ctl) begin
                bad++;
                $display("FAIL full_ctl k=%0d got rd/v/l/b=%b want=%b", k, {fifo_read, m_valid, m_last, busy}, exp_ctl);
            end
            if (exp_ctl[2]) begin
                total++;
                if (m_data !== exp_data) begin bad++; $display("FAIL full_data k=%0d got=%h want=%h", k, m_data, exp_data); end
            end
            tick;
        end
        total++;
        if (fifo_fill_level !== 6'd0) begin bad++; $display("FAIL full_fill got=%0d want=0", fifo_fill_level); end
    endtask

    task automatic test_flush_partial;
        logic [3:0]  exp_ctl;
        logic [31:0] exp_data;
        m_ready = 1'b1;
        push_words(32'h20, 3);
        for (int k = 0; k < 10; k++) begin
            flush    = (k == 0);
            #1;
            exp_ctl  = {(k >= 2 && k <= 4), (k >= 4 && k <= 6), (k == 6), (k >= 2 && k <= 6)};
            exp_data = 32'h20 + 32'(k - 4);
            total++;
            if ({fifo_read, m_valid, m_last, busy} !== exp_ctl) begin
                bad++;
                $display("FAIL flush_ctl k=%0d got rd/v/l/b=%b want=%b", k, {fifo_read, m_valid, m_last, busy}, exp_ctl);
            end
            if (exp_ctl[2]) begin
                total++;
                if (m_data !== exp_data) begin bad++; $display("FAIL flush_data k=%0d got=%h want=%h", k, m_data, exp_data); end
            end
            tick;
        end
        flush = 1'b0;
        total += 2;
        if (dut.burst_len_q !== 6'd3) begin bad++; $display("FAIL flush_len got=%0d want=3", dut.burst_len_q); end
        if (fifo_fill_level !== 6'd0) begin bad++; $display("FAIL flush_fill got=%0d want=0", fifo_fill_level); end
    endtask

    task automatic test_back_to_back;
        int got = 0;
        int max_occ = 0;
        int occ;
        int extra = 0;
        push_words(32'h40, 16);
        for (int c = 0; c < 300 && got < 16; c++) begin
            m_ready = (c % 2 == 0);
            #1;
            occ = int'(dut.in_flight_q) + int'(dut.skid_count_s);
            if (occ > max_occ) max_occ = occ;
            if (m_valid && m_ready) begin
                total += 2;
                if (m_data !== 32'h40 + 32'(got)) begin bad++; $display("FAIL b2b_data i=%0d got=%h want=%h", got, m_data, 32'h40 + 32'(got)); end
                if (m_last !== (got % 8 == 7)) begin bad++; $display("FAIL b2b_last i=%0d got=%b want=%b", got, m_last, (got % 8 == 7)); end
                got++;
            end
            tick;
        end
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (m_valid) extra++;
            tick;
        end
        total += 4;
        if (got !== 16) begin bad++; $display("FAIL b2b_count got=%0d want=16", got); end
        if (max_occ > 2) begin bad++; $display("FAIL b2b_occupancy got=%0d want<=2", max_occ); end
        if (extra !== 0) begin bad++; $display("FAIL b2b_extra got=%0d want=0", extra); end
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid;
        int acc = 0;
        int quiet = 0;
        int got = 0;
        m_ready = 1'b1;
        push_words(32'h60, 8);
        for (int n = 0; n < 40 && acc < 4; n++) begin
            if (m_valid && m_ready) acc++;
            tick;
        end
        reset = 1'b0;
        tick;
        total += 4;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", m_valid); end
        if (fifo_read !== 1'b0) begin bad++; $display("FAIL rstmid_read got=%b want=0", fifo_read); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        if (acc !== 4) begin bad++; $display("FAIL rstmid_acc got=%0d want=4", acc); end
        reset = 1'b1;
        push_words(32'h70, 5);
        for (int n = 0; n < 20; n++) begin
            if (m_valid || fifo_read || busy) quiet++;
            tick;
        end
        total++;
        if (quiet !== 0) begin bad++; $display("FAIL rstmid_quiet got=%0d want=0", quiet); end
        push_words(32'h75, 3);
        for (int n = 0; n < 40 && got < 8; n++) begin
            if (m_valid && m_ready) begin
                total += 2;
                if (m_data !== 32'h70 + 32'(got)) begin bad++; $display("FAIL rstmid_data i=%0d got=%h want=%h", got, m_data, 32'h70 + 32'(got)); end
                if (m_last !== (got == 7)) begin bad++; $display("FAIL rstmid_last i=%0d got=%b want=%b", got, m_last, (got == 7)); end
                got++;
            end
            tick;
        end
        total++;
        if (got !== 8) begin bad++; $display("FAIL rstmid_count got=%0d want=8", got); end
        tick;
    endtask

    task automatic test_timeout;
        int first_rd = -1;
        int got = 0;
        int seen = 0;
        m_ready = 1'b1;
        push_words(32'h80, 2);
`ifdef FIFO_BURST_TIMEOUT_EN
        for (int k = 0; k < 300 && got < 2; k++) begin
            if (fifo_read && first_rd < 0) first_rd = k;
            if (m_valid && m_ready) begin
                total += 2;
                if (m_data !== 32'h80 + 32'(got)) begin bad++; $display("FAIL tmo_data i=%0d got=%h want=%h", got, m_data, 32'h80 + 32'(got)); end
                if (m_last !== (got == 1)) begin bad++; $display("FAIL tmo_last i=%0d got=%b want=%b", got, m_last, (got == 1)); end
                got++;
            end
            tick;
        end
        total += 2;
        if (first_rd !== 65) begin bad++; $display("FAIL tmo_start got=%0d want=65", first_rd); end
        if (got !== 2) begin bad++; $display("FAIL tmo_count got=%0d want=2", got); end
`else
        for (int k = 0; k < 200; k++) begin
            if (m_valid || fifo_read || busy) seen++;
            tick;
        end
        total += 2;
        if (seen !== 0) begin bad++; $display("FAIL notmo_quiet got=%0d want=0", seen); end
        if (fifo_fill_level !== 6'd2) begin bad++; $display("FAIL notmo_fill got=%0d want=2", fifo_fill_level); end
`endif
    endtask

    initial begin
        reset   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        test_reset;
        test_full_burst;
        test_flush_partial;
        test_back_to_back;
        test_reset_mid;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Downstream stage of the fifo core: pops words through its read port and emits them as a valid/ready stream framed into bursts with a last flag.
- Starts a burst only when the fifo holds a full burst, or a short one on flush.
- Absorbs the fifo's registered read latency with an internal skid buffer, so downstream back-pressure never loses a popped word.

Parameters:
- WIDTH, 32, data word width; must match the fifo.
- DEPTH, 32, depth of the feeding fifo; sets FILLBITS = $clog2(DEPTH+1).
- BURST_LEN, 8, words per full burst; range 1..DEPTH.
- READ_LATENCY, 1, cycles from fifo_read high to the popped word valid on fifo_dataout; range 1..3.
- TIMEOUT, 64, idle cycles before a partial burst is forced; only used with the optional feature.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low (0 = reset), sampled on clk.
- fifo_dataout  input  WIDTH  fifo head data (link.dataout).
- fifo_fill_level  input  FILLBITS  fifo occupancy (link.fillLevel).
- fifo_read  output  1  pop strobe to fifo (link.read); one word per high cycle.
- flush  input  1  pulse; request a partial burst of whatever is present.
- m_data  output  WIDTH  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready.
- m_last  output  1  high with the final word of each burst.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0 at a clk edge), all outputs: fifo_read=0, m_valid=0, m_last=0, busy=0, m_data=0.
  - State=IDLE, all counters 0, skid buffer emptied, flush latch cleared.
  - Words popped but not yet delivered are discarded; the fifo is reset in the same cycle by the top level.
- Flush latch: set by flush==1 in any state; cleared when a burst starts from IDLE.
- FSM states: IDLE, BURST, DRAIN.
- IDLE transitions:
  - fill_level >= BURST_LEN: burst_len_q = BURST_LEN, go to BURST.
  - Else flush latch set and fill_level != 0: burst_len_q = fill_level, go to BURST.
  - Else flush latch set and fill_level == 0: clear the latch, stay in IDLE.
- BURST:
  - fifo_read=1 when reads_issued < burst_len_q and (in_flight + skid_count) < SKID_DEPTH, where SKID_DEPTH = READ_LATENCY+1.
  - When reads_issued reaches burst_len_q, go to DRAIN.
- DRAIN: no reads. When the word with m_last is accepted (m_valid & m_ready & m_last), go to IDLE. The same transition applies from BURST if that acceptance occurs there.
- Popped data path:
  - A READ_LATENCY-deep shift register of read strobes marks capture cycles.
  - fifo_dataout is written into the skid buffer exactly READ_LATENCY cycles after each fifo_read.
- Read safety: burst_len_q never exceeds the fill_level snapshot taken at burst start, so every pop targets a valid word. The fifo is non-circular here and the writer only adds words.
- Stream side:
  - m_valid = skid buffer non-empty.
  - m_data = skid head, combinational from registered storage.
  - Transfer when m_valid & m_ready.
  - m_last = m_valid & (delivered_count == burst_len_q-1).
- Back-pressure: m_valid holds and m_data/m_last stay stable until accepted.
- Throughput: with m_ready held at 1 and fill sufficient, one word per cycle after the initial READ_LATENCY bubble.
- Widths:
  - reads_issued, delivered_count and burst_len_q are FILLBITS wide.
  - in_flight is $clog2(READ_LATENCY+1) wide.
  - Counters never wrap; all compares are unsigned.
- Simultaneous events:
  - A skid push and pop in the same cycle keep the count unchanged.
  - A flush arriving during BURST/DRAIN is held in the latch for the next IDLE.
  - Completing a burst and having fill >= BURST_LEN in the same cycle: go to IDLE first; the next burst starts one cycle later.
- busy = (state != IDLE).

Optional Feature:
- Macro FIFO_BURST_TIMEOUT_EN.
- When defined:
  - An idle counter increments each IDLE cycle with 0 < fill_level < BURST_LEN.
  - It clears otherwise, on burst start, and on reset.
  - Reaching TIMEOUT sets the flush latch.
- When undefined: no counter logic; partial bursts occur only on flush.

Decomposition:
- Package libfifo_pkg holds:
  - typedef enum burstState_t {IDLE, BURST, DRAIN};
  - the FILLBITS calculation as a function fillBits(depth);
  - the existing fillStatus struct, moved there.
- One sub-module: fifo_skid_buffer (WIDTH, SKID_DEPTH). Small register fifo with push/pop, count, head output, synchronous active-low clear.

Test Plan:
- BURST_LEN=8, preload 8 words 0x10..0x17, m_ready=1 -> fifo_read high 8 consecutive cycles; m_data 0x10..0x17 on 8 consecutive cycles starting READ_LATENCY+1 cycles after the first read; m_last only with 0x17; busy drops the cycle after.
- Preload 3 words, pulse flush -> burst_len_q=3; 3 words delivered, m_last with the 3rd; fifo_fill_level ends at 0.
- Preload 16 words, m_ready toggling 1/0 every cycle -> no lost or duplicated words; in_flight+skid_count never exceeds 2 with READ_LATENCY=1; two bursts, each with m_last on its 8th word.
- Drop reset to 0 mid-burst after 4 words delivered -> next cycle: m_valid=0, fifo_read=0, busy=0; after release, nothing is emitted until fill >= 8.
- With FIFO_BURST_TIMEOUT_EN and TIMEOUT=64, preload 2 words -> burst of 2 starts 64 cycles later, m_last on the 2nd word. Without the macro, no output after 200 cycles.
